nibble_serial_subtractor: RTL and testbench

- Multi-cycle, nibble-serial subtractor: computes diff = a − b − bin over a WIDTH = 4*NIBBLES word, one 4-bit borrow-lookahead slice per clock.
- Inverse-direction companion to the team's registered 4-bit CLA adder; same propagate/generate lookahead structure, applied to borrows.
- Sits in the datapath as a start/done coprocessor; operands are captured on start, and the result is held stable until the next operation.

---
 rtl/nibble_serial_subtractor.sv | 129 ++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit borrow-lookahead slice per clock.
// Optional two's-complement overflow output enabled by defining NIBBLE_SUB_OVF_FLAG_EN.
module nibble_serial_subtractor #(
   parameter int NIBBLES = 4,
   localparam int WIDTH = 4*NIBBLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef NIBBLE_SUB_OVF_FLAG_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_next;
   logic             load, step, last;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
   logic             borrow;
   logic [3:0]       p, g, d_nib;
   logic [4:0]       bc;
   logic [WIDTH+3:0] res_cat;
`ifdef NIBBLE_SUB_OVF_FLAG_EN
   logic             a_msb, b_msb;
`endif

   // Operands shift right one nibble per step, so the active slice is always bits [3:0].
   always_comb begin
      p     = ~(a_sh[3:0] ^ b_sh[3:0]);
      g     = ~a_sh[3:0] & b_sh[3:0];
      bc[0] = borrow;
      bc[1] = g[0] | (p[0] & borrow);
      bc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & borrow);
      bc[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & borrow);
      bc[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & borrow);
      d_nib    = a_sh[3:0] ^ b_sh[3:0] ^ bc[3:0];
      res_cat  = {d_nib, res_sh};
      res_next = res_cat[WIDTH+3:4];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == CW'(NIBBLES-1)) begin
               last       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state == RUN);

   // Visible outputs only move on the final slice, so partial results stay hidden.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         borrow <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
`ifdef NIBBLE_SUB_OVF_FLAG_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         ovf    <= 1'b0;
`endif
      end else begin
         done <= last;
         if (load) begin
            a_sh   <= a_in;
            b_sh   <= b_in;
            borrow <= bin;
            cnt    <= '0;
`ifdef NIBBLE_SUB_OVF_FLAG_EN
            a_msb  <= a_in[WIDTH-1];
            b_msb  <= b_in[WIDTH-1];
`endif
         end
         if (step) begin
            a_sh   <= a_sh >> 4;
            b_sh   <= b_sh >> 4;
            res_sh <= res_next;
            borrow <= bc[4];
            cnt    <= cnt + 1'b1;
         end
         if (last) begin
            diff <= res_next;
            bout <= bc[4];
`ifdef NIBBLE_SUB_OVF_FLAG_EN
            ovf  <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
         end
      end
   end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor (NIBBLES=4); define NIBBLE_SUB_OVF_FLAG_EN to also check ovf.
module tb_nibble_serial_subtractor;

   localparam int NIBBLES = 4;
   localparam int WIDTH   = 4*NIBBLES;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a_in, b_in;
   logic             bin;
   logic             busy, done, bout;
   logic [WIDTH-1:0] diff;
`ifdef NIBBLE_SUB_OVF_FLAG_EN
   logic             ovf;
`endif

   int checks = 0;
   int errors = 0;

   nibble_serial_subtractor #(.NIBBLES(NIBBLES)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a_in  (a_in),
      .b_in  (b_in),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef NIBBLE_SUB_OVF_FLAG_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic bi, input logic st);
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      bin   = bi;
      start = st;
   endtask

   // One full operation; operands are scrambled during RUN to show they are not re-sampled.
   task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi,
                        input logic [WIDTH-1:0] expDiff, input logic expBout);
      int cycles;
      applyStimulus(a, b, bi, 1'b1);
      @(negedge clk);
      start = 1'b0;
      a_in  = ~a;
      b_in  = ~b;
      bin   = ~bi;
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      cycles = 0;
      while (!done && cycles < 20) begin
         @(negedge clk);
         cycles++;
         if (!done) checkOutput("busy_while_run", 32'(busy), 32'd1);
      end
      checkOutput("latency", 32'(cycles), 32'(NIBBLES));
      checkOutput("busy_at_done", 32'(busy), 32'd0);
      checkOutput("diff", 32'(diff), 32'(expDiff));
      checkOutput("bout", 32'(bout), 32'(expBout));
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("diff_held", 32'(diff), 32'(expDiff));
   endtask

   initial begin
      int doneCount;
      logic expDone;
      rst   = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      bin   = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_diff", 32'(diff), 32'd0);
      checkOutput("reset_bout", 32'(bout), 32'd0);
`ifdef NIBBLE_SUB_OVF_FLAG_EN
      checkOutput("reset_ovf", 32'(ovf), 32'd0);
`endif
      rst = 1'b0;

      runOp(16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0);
`ifdef NIBBLE_SUB_OVF_FLAG_EN
      checkOutput("ovf_1234", 32'(ovf), 32'd0);
`endif
      runOp(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
      runOp(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0);
      runOp(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
      runOp(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
      runOp(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0);
`ifdef NIBBLE_SUB_OVF_FLAG_EN
      checkOutput("ovf_8000", 32'(ovf), 32'd1);
`endif
      runOp(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1);
`ifdef NIBBLE_SUB_OVF_FLAG_EN
      checkOutput("ovf_7FFF", 32'(ovf), 32'd1);
`endif

      // A second start during RUN must be dropped entirely.
      applyStimulus(16'h1234, 16'h0235, 1'b0, 1'b1);
      @(negedge clk);
      start = 1'b0;
      applyStimulus(16'hAAAA, 16'h1111, 1'b1, 1'b1);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("ignored_start_done", 32'(done), 32'd1);
      checkOutput("ignored_start_diff", 32'(diff), 32'h0FFF);
      doneCount = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("ignored_start_no_second_done", 32'(doneCount), 32'd0);

      // Held start: accepted in the idle done cycle, so accepts land at edges T, T+5, T+10.
      applyStimulus(16'h1000, 16'h0001, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         expDone = (i == 4) || (i == 9) || (i == 14);
         checkOutput("held_start_done", 32'(done), 32'(expDone));
         if (i == 4)  checkOutput("held_start_diff0", 32'(diff), 32'h0FFF);
         if (i == 9)  checkOutput("held_start_diff1", 32'(diff), 32'h1004);
         if (i == 14) checkOutput("held_start_diff2", 32'(diff), 32'h1009);
         a_in = 16'h1000 + 16'(i + 1);
      end
      start = 1'b0;
      repeat (6) @(negedge clk);

      // Reset in the middle of an operation aborts it without a done pulse.
      applyStimulus(16'h1234, 16'h0235, 1'b0, 1'b1);
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_diff", 32'(diff), 32'd0);
      checkOutput("abort_bout", 32'(bout), 32'd0);
      doneCount = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) doneCount++;
      end
      checkOutput("abort_no_done", 32'(doneCount), 32'd0);
      runOp(16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
